// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 32-bit transceiver bus.
// Drives the active-low per-source enables that feed the 74x245 bank drivers.
// At most one bank is enabled at a time. Every change of owner, and every
// regrant to the same owner, is separated by DEAD cycles with all banks off.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   req    [N]  active-high requests; a source holds its bit high to keep the bus
//   g      [N]  active-low bank enables; either one bit low or all bits high
//   gnt    [N]  active-high grant, always ~g
//   busy        high while any enable is low
//   owner  [IW] index of the current or most recent owner; meaningful when busy
module bus_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,  // 0 = unlimited tenure
  parameter int DEAD     = 1,   // must be >= 1
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  g,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [IW-1:0] owner
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_HOLD - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_g;
  logic          rel;

  // Round-robin pick: first request at ptr+1, ptr+2, ... with wrap. The scan runs
  // from the farthest offset to the nearest so that the nearest request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N; i >= 1; i--) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
    win_g = ~(N'(1) << win_idx);
  end

  // A tenure ends when the owner drops its request or reaches the hold limit.
  always_comb begin
    rel = ~req[owner];
    if (MAX_HOLD != 0 && cnt == CNT_LAST) rel = 1'b1;
  end

  // Arbiter FSM. All outputs are registered, so req has no combinational path to g.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '1;
      gnt   <= '0;
      busy  <= 1'b0;
      owner <= '0;
      ptr   <= IW'(N - 1);
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= GRANT;
            g     <= win_g;
            gnt   <= ~win_g;
            busy  <= 1'b1;
            owner <= win_idx;
            ptr   <= win_idx;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state <= TURN;
            g     <= '1;
            gnt   <= '0;
            busy  <= 1'b0;
            dcnt  <= '0;
          end else if (cnt != '1) begin
            // Saturates instead of wrapping when the tenure is unlimited.
            cnt <= cnt + CW'(1);
          end
        end
        TURN: begin
          if (dcnt == DEAD_LAST) begin
            if (win_found) begin
              state <= GRANT;
              g     <= win_g;
              gnt   <= ~win_g;
              busy  <= 1'b1;
              owner <= win_idx;
              ptr   <= win_idx;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          g     <= '1;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter. It drives three instances: a (defaults), b with
// MAX_HOLD=4, and c with DEAD=2. Directed vectors push their expected outputs
// into a scoreboard queue, and a monitor pops and compares them on the falling
// edge. Instance c then runs with random requests while invariant and
// starvation checks are applied on every cycle.
module tb_bus_arbiter;

  localparam int N     = 8;
  localparam int MH_C  = 16;
  localparam int DEAD_C = 2;
  // One extra cycle because a request is visible half a cycle before the
  // edge that samples it.
  localparam int STARVE_BOUND = N * (MH_C + DEAD_C) + 1;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] req_a, req_b, req_c;
  logic [7:0] g_a, g_b, g_c, gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] owner_a, owner_b, owner_c;

  always #5 clk = ~clk;

  bus_arbiter #(.N(8), .MAX_HOLD(16), .DEAD(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .g(g_a), .gnt(gnt_a), .busy(busy_a), .owner(owner_a));
  bus_arbiter #(.N(8), .MAX_HOLD(4), .DEAD(1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .g(g_b), .gnt(gnt_b), .busy(busy_b), .owner(owner_b));
  bus_arbiter #(.N(8), .MAX_HOLD(MH_C), .DEAD(DEAD_C)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .g(g_c), .gnt(gnt_c), .busy(busy_c), .owner(owner_c));

  typedef struct {
    int         sel;
    logic [7:0] g;
    logic       chk_own;
    logic [2:0] own;
    int         tid;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic rand_on = 1'b0;

  // Apply a request to one instance, let one edge pass, and queue the expected result.
  task automatic cyc(input int sel, input logic [7:0] r, input logic [7:0] eg,
                     input logic co, input logic [2:0] eo, input int tid);
    exp_t e;
    case (sel)
      0:       req_a = r;
      1:       req_b = r;
      default: req_c = r;
    endcase
    @(posedge clk);
    e.sel = sel; e.g = eg; e.chk_own = co; e.own = eo; e.tid = tid;
    sb.push_back(e);
    #1;
  endtask

  task automatic expect_now(input int sel, input logic [7:0] eg, input int tid);
    exp_t e;
    e.sel = sel; e.g = eg; e.chk_own = 1'b1; e.own = 3'd0; e.tid = tid;
    sb.push_back(e);
  endtask

  // Scoreboard monitor.
  exp_t       me;
  logic [7:0] mg, mgnt;
  logic       mbusy;
  logic [2:0] mown;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me = sb.pop_front();
      case (me.sel)
        0:       begin mg = g_a; mgnt = gnt_a; mbusy = busy_a; mown = owner_a; end
        1:       begin mg = g_b; mgnt = gnt_b; mbusy = busy_b; mown = owner_b; end
        default: begin mg = g_c; mgnt = gnt_c; mbusy = busy_c; mown = owner_c; end
      endcase
      checks++;
      if (mg !== me.g) begin
        errors++;
        $display("FAIL t%0d dut%0d g: got %h want %h @%0t", me.tid, me.sel, mg, me.g, $time);
      end
      checks++;
      if (mgnt !== ~me.g || mbusy !== (me.g != 8'hFF)) begin
        errors++;
        $display("FAIL t%0d dut%0d gnt/busy: got %h/%b want %h/%b @%0t",
                 me.tid, me.sel, mgnt, mbusy, ~me.g, (me.g != 8'hFF), $time);
      end
      if (me.chk_own) begin
        checks++;
        if (mown !== me.own) begin
          errors++;
          $display("FAIL t%0d dut%0d owner: got %0d want %0d @%0t", me.tid, me.sel, mown, me.own, $time);
        end
      end
    end
  end

  // Random-phase invariant and starvation monitor for instance c.
  logic [7:0] prev_gc;
  int         ones_run;
  int         waits [N];
  int         maxw;
  logic       bad;
  always @(negedge clk) begin
    if (rst) begin
      prev_gc  = 8'hFF;
      ones_run = DEAD_C;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else if (rand_on) begin
      bad = 1'b0;
      if ($countones(~g_c) > 1) bad = 1'b1;
      if (gnt_c !== ~g_c) bad = 1'b1;
      if (busy_c !== (g_c != 8'hFF)) bad = 1'b1;
      if (busy_c && !gnt_c[owner_c]) bad = 1'b1;
      if (g_c != 8'hFF && prev_gc != 8'hFF && g_c != prev_gc) bad = 1'b1;
      if (g_c != 8'hFF && prev_gc == 8'hFF && ones_run < DEAD_C) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL inv: g=%h prev=%h gnt=%h busy=%b owner=%0d dead_run=%0d need>=%0d @%0t",
                 g_c, prev_gc, gnt_c, busy_c, owner_c, ones_run, DEAD_C, $time);
      end
      ones_run = (g_c == 8'hFF) ? ones_run + 1 : 0;
      prev_gc  = g_c;
      maxw = 0;
      for (int i = 0; i < N; i++) begin
        waits[i] = (req_c[i] && !gnt_c[i]) ? waits[i] + 1 : 0;
        if (waits[i] > maxw) maxw = waits[i];
      end
      checks++;
      if (maxw > STARVE_BOUND) begin
        errors++;
        $display("FAIL starve: wait %0d cycles, allowed %0d @%0t", maxw, STARVE_BOUND, $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_a = 8'h00; req_b = 8'h00; req_c = 8'h00;

    // T1: reset with every request raised
    cyc(0, 8'hFF, 8'hFF, 1'b1, 3'd0, 1);
    expect_now(1, 8'hFF, 1);
    expect_now(2, 8'hFF, 1);
    rst = 1'b0;

    // T2: single requester 3, release, then requester 4 from IDLE
    repeat (5) cyc(0, 8'h08, 8'hF7, 1'b1, 3'd3, 2);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 2);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 2);
    cyc(0, 8'h10, 8'hEF, 1'b1, 3'd4, 2);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 2);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 2);

    // T3: two requesters held; timeout rotates between them
    rst = 1'b1;
    cyc(0, 8'h11, 8'hFF, 1'b1, 3'd0, 3);
    rst = 1'b0;
    repeat (16) cyc(0, 8'h11, 8'hFE, 1'b1, 3'd0, 3);
    cyc(0, 8'h11, 8'hFF, 1'b0, 3'd0, 3);
    repeat (16) cyc(0, 8'h11, 8'hEF, 1'b1, 3'd4, 3);
    cyc(0, 8'h11, 8'hFF, 1'b0, 3'd0, 3);
    repeat (3) cyc(0, 8'h11, 8'hFE, 1'b1, 3'd0, 3);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 3);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 3);

    // T5: reset during the tenure of source 5, then source 0 wins over 5
    rst = 1'b1;
    cyc(0, 8'h00, 8'hFF, 1'b1, 3'd0, 5);
    rst = 1'b0;
    repeat (3) cyc(0, 8'h20, 8'hDF, 1'b1, 3'd5, 5);
    rst = 1'b1;
    cyc(0, 8'h21, 8'hFF, 1'b1, 3'd0, 5);
    rst = 1'b0;
    repeat (2) cyc(0, 8'h21, 8'hFE, 1'b1, 3'd0, 5);
    cyc(0, 8'h00, 8'hFF, 1'b0, 3'd0, 5);

    // T4: MAX_HOLD=4 sole requester is regranted after one dead cycle
    rst = 1'b1;
    cyc(1, 8'h00, 8'hFF, 1'b1, 3'd0, 4);
    rst = 1'b0;
    repeat (2) begin
      repeat (4) cyc(1, 8'h04, 8'hFB, 1'b1, 3'd2, 4);
      cyc(1, 8'h04, 8'hFF, 1'b0, 3'd0, 4);
    end
    cyc(1, 8'h04, 8'hFB, 1'b1, 3'd2, 4);
    cyc(1, 8'h00, 8'hFF, 1'b0, 3'd0, 4);

    // T6: DEAD=2 gives two all-off cycles before the regrant
    rst = 1'b1;
    cyc(2, 8'h00, 8'hFF, 1'b1, 3'd0, 6);
    rst = 1'b0;
    repeat (16) cyc(2, 8'h02, 8'hFD, 1'b1, 3'd1, 6);
    repeat (2) cyc(2, 8'h02, 8'hFF, 1'b0, 3'd0, 6);
    cyc(2, 8'h02, 8'hFD, 1'b1, 3'd1, 6);
    cyc(2, 8'h00, 8'hFF, 1'b0, 3'd0, 6);

    // T7: random requests on instance c with invariant and starvation checks
    rst = 1'b1;
    req_c = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_on = 1'b1;
    repeat (10000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) req_c[i] = ~req_c[i];
      @(posedge clk); #1;
    end
    rand_on = 1'b0;

    // Drain the scoreboard, with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
